// File: rtl/matrix_pkg.sv
// Shared constants and write-side state type for the matrix transpose buffer.
// Both the write and read controllers take their default frame geometry from here.
package matrix_pkg;

   localparam int DEF_ROW         = 64;
   localparam int DEF_CLO         = 2400;
   localparam int DEF_ADDR_WIDTH  = 18;
   localparam int DEF_DATA_WIDTH  = 32;
   localparam int FRAME_WORDS     = DEF_ROW * DEF_CLO;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      LAST    = 2'd1,
      CMD     = 2'd2,
      WAIT_RD = 2'd3
   } wr_state_t;

endpackage

// File: rtl/wr_ctrl.sv
// Write-side controller of the transpose buffer: fills one ROW x CLO frame into RAM, then hands off to the reader.
// Optional completed-frame counter output enabled by defining WR_CTRL_FRAME_CNT_EN.
//
// state   | meaning
// FILL    | accepting stream words, writing sequential addresses
// LAST    | final word of the frame being written, stream stalled
// CMD     | rd_command high, frame fully in RAM
// WAIT_RD | stream stalled until the reader reports rd_finish
module wr_ctrl
   import matrix_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ROW        = DEF_ROW,
   parameter int CLO        = DEF_CLO
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_command,
`ifdef WR_CTRL_FRAME_CNT_EN
   output logic [15:0]           frame_cnt,
`endif
   input  logic                  rd_finish
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROW * CLO - 1);

   wr_state_t             state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  xfer;

   assign s_ready = (state == FILL);
   assign xfer    = s_valid && s_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FILL;
         cnt        <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         rd_command <= 1'b0;
`ifdef WR_CTRL_FRAME_CNT_EN
         frame_cnt  <= '0;
`endif
      end else begin
         wr_en      <= xfer;
         rd_command <= 1'b0;
         if (xfer) begin
            wr_addr <= cnt;
            wr_data <= s_data;
         end
         unique case (state)
            FILL: begin
               if (xfer) begin
                  // counter only wraps through the end-of-frame transition
                  if (cnt == LAST_ADDR) begin
                     cnt   <= '0;
                     state <= LAST;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            LAST: begin
               state      <= CMD;
               rd_command <= 1'b1;
            end
            CMD: begin
               state <= WAIT_RD;
`ifdef WR_CTRL_FRAME_CNT_EN
               frame_cnt <= frame_cnt + 16'd1;
`endif
            end
            WAIT_RD: begin
               if (rd_finish) state <= FILL;
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_wr_ctrl.sv
// Directed bench for wr_ctrl with a small 4x3 frame; cycle table plus reset and multi-frame sequences.
module tb_wr_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_command;
   logic        rd_finish = 1'b0;
`ifdef WR_CTRL_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int checks = 0;
   int errors = 0;

   wr_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .ROW(4), .CLO(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s_valid(s_valid),
      .s_data(s_data),
      .s_ready(s_ready),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_command(rd_command),
`ifdef WR_CTRL_FRAME_CNT_EN
      .frame_cnt(frame_cnt),
`endif
      .rd_finish(rd_finish)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        fin;
      logic        sr;
      logic        we;
      logic [3:0]  a;
      logic [31:0] wd;
      logic        cmd;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic v, input logic [31:0] d, input logic fin,
                               input logic sr, input logic we, input logic [3:0] a,
                               input logic [31:0] wd, input logic cmd);
      vec_t r;
      r.v = v; r.d = d; r.fin = fin;
      r.sr = sr; r.we = we; r.a = a; r.wd = wd; r.cmd = cmd;
      tbl.push_back(r);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Feeds one full frame back-to-back, waits for rd_command, then answers with rd_finish.
   task automatic run_frame(input logic [31:0] base, input int n);
      bit found;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k > 0) begin
            chk("frm_wen", 32'(wr_en), 32'd1);
            chk("frm_addr", 32'(wr_addr), 32'(k - 1));
            chk("frm_data", wr_data, base + 32'(k - 1));
         end
         s_valid = 1'b1;
         s_data  = base + 32'(k);
      end
      @(negedge clk);
      s_valid = 1'b0;
      chk("frm_last_addr", 32'(wr_addr), 32'd11);
      chk("frm_last_data", wr_data, base + 32'd11);
      found = 1'b0;
      for (int t = 0; t < 5 && !found; t++) begin
         @(negedge clk);
         if (rd_command) found = 1'b1;
      end
      chk("frm_cmd_seen", 32'(found), 32'd1);
      @(negedge clk);
      chk("frm_cmd_clear", 32'(rd_command), 32'd0);
`ifdef WR_CTRL_FRAME_CNT_EN
      chk("frame_cnt", 32'(frame_cnt), 32'(n));
`endif
      rd_finish = 1'b1;
      @(negedge clk);
      rd_finish = 1'b0;
      chk("frm_ready_after_fin", 32'(s_ready), 32'd1);
   endtask

   initial begin
      // frame 1: 12 back-to-back words
      add(1, 32'h100, 0, 1, 0, 4'd0, 32'h0, 0);
      for (int k = 1; k < 12; k++)
         add(1, 32'h100 + 32'(k), 0, 1, 1, 4'(k - 1), 32'h100 + 32'(k - 1), 0);
      // LAST, CMD, then WAIT_RD with 0x200 held on the stream
      add(1, 32'h200, 0, 0, 1, 4'd11, 32'h10B, 0);
      add(1, 32'h200, 0, 0, 0, 4'd11, 32'h10B, 1);
      for (int k = 14; k < 21; k++)
         add(1, 32'h200, 0, 0, 0, 4'd11, 32'h10B, 0);
      add(1, 32'h200, 1, 0, 0, 4'd11, 32'h10B, 0);
      add(1, 32'h200, 0, 1, 0, 4'd11, 32'h10B, 0);
      // gapped input
      add(0, 32'h0,   0, 1, 1, 4'd0, 32'h200, 0);
      add(1, 32'h301, 0, 1, 0, 4'd0, 32'h200, 0);
      add(0, 32'h0,   0, 1, 1, 4'd1, 32'h301, 0);
      add(1, 32'h302, 0, 1, 0, 4'd1, 32'h301, 0);
      add(0, 32'h0,   0, 1, 1, 4'd2, 32'h302, 0);
      // remainder of frame 2 with a stray rd_finish at word 5
      for (int k = 3; k < 12; k++)
         add(1, 32'h400 + 32'(k), (k == 5) ? 1'b1 : 1'b0, 1, (k > 3) ? 1'b1 : 1'b0,
             (k > 3) ? 4'(k - 1) : 4'd2, (k > 3) ? 32'h400 + 32'(k - 1) : 32'h302, 0);
      // LAST, CMD with rd_finish (ignored), WAIT_RD with rd_finish, back to FILL
      add(0, 32'h0, 0, 0, 1, 4'd11, 32'h40B, 0);
      add(0, 32'h0, 1, 0, 0, 4'd11, 32'h40B, 1);
      add(0, 32'h0, 1, 0, 0, 4'd11, 32'h40B, 0);
      add(0, 32'h0, 0, 1, 0, 4'd11, 32'h40B, 0);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), 32'(s_ready), 32'(tbl[i].sr));
         chk($sformatf("v%0d_wen", i), 32'(wr_en), 32'(tbl[i].we));
         chk($sformatf("v%0d_addr", i), 32'(wr_addr), 32'(tbl[i].a));
         chk($sformatf("v%0d_data", i), wr_data, tbl[i].wd);
         chk($sformatf("v%0d_cmd", i), 32'(rd_command), 32'(tbl[i].cmd));
         s_valid   = tbl[i].v;
         s_data    = tbl[i].d;
         rd_finish = tbl[i].fin;
      end
      @(negedge clk);
      s_valid = 1'b0;
      rd_finish = 1'b0;

      // reset after 7 words of a partial frame
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = 32'h500 + 32'(k);
      end
      @(negedge clk);
      s_valid = 1'b0;
      chk("partial_addr", 32'(wr_addr), 32'd6);
      rst_n = 1'b0;
      #1;
      chk("rst_wen", 32'(wr_en), 32'd0);
      chk("rst_addr", 32'(wr_addr), 32'd0);
      chk("rst_data", wr_data, 32'd0);
      chk("rst_cmd", 32'(rd_command), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd1);
`ifdef WR_CTRL_FRAME_CNT_EN
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         chk("post_rst_no_cmd", 32'(rd_command), 32'd0);
      end

      run_frame(32'h600, 1);
      run_frame(32'h700, 2);
      run_frame(32'h800, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wr_ctrl.md
Name: wr_ctrl

Overview:
- Write-side controller of the matrix transpose buffer.
- Accepts a row-major input stream over a valid/ready handshake and writes one ROW x CLO frame into the single-port frame RAM at sequential addresses 0 .. ROW*CLO-1.
- When the frame is complete, pulses rd_command to the column-order read controller.
- Back-pressures the stream until the reader reports rd_finish, then accepts the next frame.

Parameters:
- ADDR_WIDTH, 18, RAM address width; must satisfy 2**ADDR_WIDTH >= ROW*CLO.
- DATA_WIDTH, 32, data word width.
- ROW, 64, rows per frame.
- CLO, 2400, columns per frame (words per row).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_data  in  DATA_WIDTH  input word, row-major order.
- s_ready  out  1  block can accept a word this cycle.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_WIDTH  RAM write address.
- wr_data  out  DATA_WIDTH  RAM write data.
- rd_command  out  1  one-cycle pulse: frame complete in RAM, start read.
- rd_finish  in  1  one-cycle pulse from read controller: last address read.
- frame_cnt  out  16  completed frames (present only with WR_CTRL_FRAME_CNT_EN).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n. Everything is registered.
- Reset values: state=FILL, addr counter=0, wr_en=0, wr_addr=0, wr_data=0, rd_command=0, frame_cnt=0.
- s_ready is combinational from state: 1 only in FILL.
- Word transfer: a word moves when s_valid && s_ready at a clock edge.
- Write latency is 1 cycle. The next cycle has wr_en=1, wr_addr=counter value at acceptance, wr_data=accepted s_data.
- wr_en=0 in any cycle following no transfer. wr_addr and wr_data hold their last values when wr_en=0.
- The address counter increments by 1 per transfer. It is never skipped and never decremented.
- States:
  - FILL: accept words. A transfer at counter==ROW*CLO-1 goes to LAST and clears the counter to 0.
  - LAST: one cycle; wr_en=1 for the final word; s_ready=0. Next state CMD.
  - CMD: rd_command=1 for exactly this cycle. The final RAM write has completed, so the reader may start next cycle. Next state WAIT_RD.
  - WAIT_RD: s_ready=0. rd_finish sampled high -> FILL.
- rd_finish outside WAIT_RD is ignored (no state change, no error).
- rd_finish arriving in the CMD cycle is also ignored; it cannot legally occur there.
- s_valid held high while s_ready=0: no transfer; the word must be held by the source (standard valid/ready).
- Gapped input (s_valid toggling) gives gapped wr_en pulses at consecutive addresses.
- Reset mid-frame: partial frame discarded, counter returns to 0, state FILL. No rd_command is issued for the partial frame.
- Address arithmetic: last-address compare uses ROW*CLO-1 evaluated at ADDR_WIDTH. The counter wraps to 0 only through the LAST transition, never by overflow.

Optional Feature:
- WR_CTRL_FRAME_CNT_EN defined:
  - frame_cnt port exists.
  - Increments by 1 in the CMD cycle (visible the cycle after).
  - Wraps 0xFFFF -> 0.
  - Cleared only by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package matrix_pkg: default ROW, CLO, ADDR_WIDTH, DATA_WIDTH constants; FRAME_WORDS = ROW*CLO; wr_state_t enum {FILL, LAST, CMD, WAIT_RD}. rd_ctrl shares these constants.
- No sub-module; the counter and FSM stay in one module.

Test Plan (ROW=4, CLO=3, ADDR_WIDTH=4, DATA_WIDTH=32 unless noted):
- Reset then 12 back-to-back words 0x100..0x10B, then rd_finish pulse 10 cycles later -> wr_en high 12 consecutive cycles with wr_addr 0..11 and data 0x100..0x10B; rd_command single pulse 2 cycles after the last acceptance; s_ready low from the last acceptance until the cycle after rd_finish.
- s_valid held high through WAIT_RD with data 0x200 -> no wr_en; after rd_finish, 0x200 is written at wr_addr 0.
- s_valid toggled 1,0,1,0 during FILL -> wr_en pulses alternate; addresses consecutive 0,1,2...
- rd_finish pulsed during FILL at word 5 -> ignored; frame continues to address 11 and rd_command fires normally.
- rst_n low after 7 words, then released -> outputs at reset values, no rd_command; the next frame starts at wr_addr 0.
- WR_CTRL_FRAME_CNT_EN defined, 3 full frames each with a rd_finish response -> frame_cnt reads 1, 2, 3 after the respective CMD cycles.
